// File: rtl/mfu_pkg.sv
// Shared encodings and default parameters for the multi-function vector unit.
package mfu_pkg;

  typedef enum logic [1:0] {
    OP_ACTIVATION = 2'b00,
    OP_ELT_ADD    = 2'b01,
    OP_ELT_MUL    = 2'b10,
    OP_BYPASS     = 2'b11
  } mfu_op_e;

  typedef enum logic {
    ACT_RELU = 1'b0,
    ACT_CLIP = 1'b1
  } mfu_act_e;

  localparam int DEF_DESIGN_SIZE = 10;
  localparam int DEF_DWIDTH      = 16;
  localparam int DEF_VRF_AWIDTH  = 10;
  localparam int DEF_FRAC_BITS   = 8;

endpackage

// File: rtl/mfu_lane.sv
// One lane of the vector unit: saturating add, fixed-point multiply, activation and bypass.
module mfu_lane
  import mfu_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic [1:0]        op_i,
  input  logic              act_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              sat_o
);

  localparam logic [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MAX_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] ONE     = DWIDTH'(1) << FRAC_BITS;

  logic [DWIDTH:0]            sum;
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [2*DWIDTH-1:0] prodShift;
  logic                       addOvf;
  logic                       mulOvf;
  logic [DWIDTH-1:0]          addSat;
  logic [DWIDTH-1:0]          mulSat;
  logic [DWIDTH-1:0]          actRes;

  // Overflow is detected from the bits above the result sign rather than by compares.
  always_comb begin
    sum       = {a_i[DWIDTH-1], a_i} + {b_i[DWIDTH-1], b_i};
    addOvf    = sum[DWIDTH] ^ sum[DWIDTH-1];
    addSat    = addOvf ? (sum[DWIDTH] ? MAX_NEG : MAX_POS) : sum[DWIDTH-1:0];

    prod      = $signed({{DWIDTH{a_i[DWIDTH-1]}}, a_i}) * $signed({{DWIDTH{b_i[DWIDTH-1]}}, b_i});
    prodShift = prod >>> FRAC_BITS;
    mulOvf    = !((&prodShift[2*DWIDTH-1:DWIDTH-1]) || !(|prodShift[2*DWIDTH-1:DWIDTH-1]));
    mulSat    = mulOvf ? (prodShift[2*DWIDTH-1] ? MAX_NEG : MAX_POS) : prodShift[DWIDTH-1:0];

    if (a_i[DWIDTH-1]) begin
      actRes = '0;
    end else if (act_i == ACT_CLIP && a_i > ONE) begin
      actRes = ONE;
    end else begin
      actRes = a_i;
    end
  end

  always_comb begin
    res_o = a_i;
    sat_o = 1'b0;
    case (op_i)
      OP_ACTIVATION: res_o = actRes;
      OP_ELT_ADD: begin
        res_o = addSat;
        sat_o = addOvf;
      end
      OP_ELT_MUL: begin
        res_o = mulSat;
        sat_o = mulOvf;
      end
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/mfu_vec_pipe.sv
// Two-stage vector pipeline: stage A captures the request and VRF operand, the output
// register captures the per-lane results. A single advance signal stalls both stages.
module mfu_vec_pipe
  import mfu_pkg::*;
#(
  parameter int DESIGN_SIZE = DEF_DESIGN_SIZE,
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int VRF_AWIDTH  = DEF_VRF_AWIDTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    op,
  input  logic                          activation_type,
  input  logic [VRF_AWIDTH-1:0]         vrf_rd_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] primary_inp,
  input  logic                          vrf_wr_en,
  input  logic [VRF_AWIDTH-1:0]         vrf_wr_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] vrf_wr_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          sat_flag,
  input  logic                          sat_clear,
  output logic                          busy
);

  localparam int VW = DESIGN_SIZE * DWIDTH;

  logic [VW-1:0]          vrf_q [2**VRF_AWIDTH];
  logic [VW-1:0]          aVrf_q;
  logic                   aValid_q;
  logic [1:0]             aOp_q;
  logic                   aAct_q;
  logic [VW-1:0]          aPrim_q;
  logic                   outValid_q;
  logic [VW-1:0]          outData_q;
  logic                   satFlag_q;
  logic                   satFlag_d;
  logic [VW-1:0]          laneRes;
  logic [DESIGN_SIZE-1:0] laneSat;
  logic                   advance;
  logic                   accept;

  assign advance   = !outValid_q || out_ready;
  assign accept    = in_valid && advance;
  assign in_ready  = advance;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign sat_flag  = satFlag_q;
  assign busy      = aValid_q || outValid_q;

  // The VRF is left unreset so it can map onto block RAM; the read register is
  // read-first because it samples the array before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (vrf_wr_en) begin
      vrf_q[vrf_wr_addr] <= vrf_wr_data;
    end
    if (accept) begin
      aVrf_q <= vrf_q[vrf_rd_addr];
    end
  end

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    mfu_lane #(
      .DWIDTH    (DWIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .op_i  (aOp_q),
      .act_i (aAct_q),
      .a_i   (aPrim_q[i*DWIDTH +: DWIDTH]),
      .b_i   (aVrf_q[i*DWIDTH +: DWIDTH]),
      .res_o (laneRes[i*DWIDTH +: DWIDTH]),
      .sat_o (laneSat[i])
    );
  end

  // A saturating result being loaded wins over a clear on the same edge.
  always_comb begin
    satFlag_d = satFlag_q;
    if (advance && aValid_q && (|laneSat)) begin
      satFlag_d = 1'b1;
    end else if (sat_clear) begin
      satFlag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aValid_q   <= 1'b0;
      aOp_q      <= OP_BYPASS;
      aAct_q     <= ACT_RELU;
      aPrim_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      satFlag_q  <= 1'b0;
    end else begin
      satFlag_q <= satFlag_d;
      if (advance) begin
        aValid_q   <= in_valid;
        outValid_q <= aValid_q;
        if (in_valid) begin
          aOp_q   <= op;
          aAct_q  <= activation_type;
          aPrim_q <= primary_inp;
        end
        if (aValid_q) begin
          outData_q <= laneRes;
        end
      end
    end
  end

endmodule
